// File: rtl/ram_pkg.sv
// Shared defaults and clear-sweep state type for the dual-port RAM slice.
package ram_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned BYTE_W         = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

   // Number of byte lanes in a word.
   function automatic int unsigned num_lanes(input int unsigned data_width);
      return data_width / BYTE_W;
   endfunction

endpackage

// File: rtl/ram_dp_clear_ctrl.sv
// Post-reset clear sweep: walks every address once, then releases the RAM
// for normal traffic.
module ram_dp_clear_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam int unsigned            DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   ram_state_t            state;
   ram_state_t            state_next;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_next;
   logic                  busy_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         busy  <= busy_next;
      end
   end

   // Sweep advances one address per cycle and exits after the last one.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      busy_next  = 1'b0;
      case (state)
         ST_CLEAR: begin
            cnt_next = cnt + ADDR_WIDTH'(1);
            if (cnt == LAST_ADDR) begin
               state_next = ST_READY;
               cnt_next   = '0;
            end
         end
         ST_READY: state_next = ST_READY;
      endcase
      busy_next = (state_next == ST_CLEAR);
   end

   assign clr_we   = busy;
   assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp.sv
// Single-clock simple dual-port RAM with byte enables, write-first read
// bypass and a self-clearing sweep after reset.
// Optional per-lane even parity with error injection: define RAM_DP_PARITY_EN.
module ram_dp
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_WIDTH-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic [DATA_WIDTH/8-1:0]    wr_be,
   input  logic                       rd_en,
   input  logic [ADDR_WIDTH-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic                       busy
`ifdef RAM_DP_PARITY_EN
   ,
   input  logic                       par_inj,
   output logic                       par_err
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned NB    = num_lanes(DATA_WIDTH);

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  wr_hit;
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ram_dp_clear_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_ctrl (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign wr_acc = wr_en && !busy && !rst;
   assign rd_acc = rd_en && !busy;
   assign wr_hit = wr_acc && (wr_addr == rd_addr);

   // Write-first: lanes being written this cycle bypass the array.
   always_comb begin
      rd_word_c = mem[rd_addr];
      for (int i = 0; i < NB; i++) begin
         if (wr_hit && wr_be[i]) begin
            rd_word_c[BYTE_W*i +: BYTE_W] = wr_data[BYTE_W*i +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we && !rst) begin
         mem[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= rd_word_c;
         end
      end
   end

`ifdef RAM_DP_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] par_rd_c;
   logic [NB-1:0] par_calc_c;

   // Stored parity follows the same write-first bypass as the data.
   always_comb begin
      par_rd_c   = par_mem[rd_addr];
      par_calc_c = '0;
      for (int i = 0; i < NB; i++) begin
         if (wr_hit && wr_be[i]) begin
            par_rd_c[i] = (^wr_data[BYTE_W*i +: BYTE_W]) ^ par_inj;
         end
         par_calc_c[i] = ^rd_word_c[BYTE_W*i +: BYTE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we && !rst) begin
         par_mem[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               par_mem[wr_addr][i] <= (^wr_data[BYTE_W*i +: BYTE_W]) ^ par_inj;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_err <= 1'b0;
      end else begin
         par_err <= rd_acc && (par_rd_c != par_calc_c);
      end
   end
`endif

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp (16-bit words, 32 entries): word-level memory model with
// per-cycle compare plus directed literal checks.
module tb_ram_dp;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 5;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] wr_be = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
`ifdef RAM_DP_PARITY_EN
   logic          par_inj = 1'b0;
   logic          par_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   ram_dp #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy)
`ifdef RAM_DP_PARITY_EN
      ,
      .par_inj  (par_inj),
      .par_err  (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain array, a count of remaining clear cycles, and
   // the expected output values after each rising edge.
   logic [DW-1:0] m_mem [DEPTH];
   logic [NB-1:0] m_bad [DEPTH];
   int            m_left   = DEPTH;
   logic          seen_rst = 1'b0;
   logic [DW-1:0] e_data   = '0;
   logic          e_valid  = 1'b0;
   logic          e_busy   = 1'b1;
   logic          e_perr   = 1'b0;

   task automatic model_step();
      logic inj;
`ifdef RAM_DP_PARITY_EN
      inj = par_inj;
`else
      inj = 1'b0;
`endif
      if (rst) begin
         seen_rst = 1'b1;
         m_left   = DEPTH;
         e_valid  = 1'b0;
         e_data   = '0;
         e_busy   = 1'b1;
         e_perr   = 1'b0;
      end else if (m_left > 0) begin
         m_mem[DEPTH - m_left] = '0;
         m_bad[DEPTH - m_left] = '0;
         m_left  = m_left - 1;
         e_valid = 1'b0;
         e_perr  = 1'b0;
         e_busy  = (m_left > 0);
      end else begin
         if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
               if (wr_be[i]) begin
                  m_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                  m_bad[wr_addr][i]        = inj;
               end
            end
         end
         e_valid = rd_en;
         e_perr  = 1'b0;
         if (rd_en) begin
            e_data = m_mem[rd_addr];
            e_perr = |m_bad[rd_addr];
         end
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (seen_rst) begin
         chk("cyc_busy", 32'(busy), 32'(e_busy));
         chk("cyc_rd_valid", 32'(rd_valid), 32'(e_valid));
         chk("cyc_rd_data", 32'(rd_data), 32'(e_data));
`ifdef RAM_DP_PARITY_EN
         chk("cyc_par_err", 32'(par_err), 32'(e_perr));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      wr_be   = be;
      rd_en   = re;
      rd_addr = ra;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   // Counts edges until busy drops (bounded) and rd_valid pulses seen meanwhile.
   task automatic wait_sweep(input string name);
      int n;
      int nv;
      n  = 0;
      nv = 0;
      while (busy && n < 40) begin
         tick();
         n++;
         if (rd_valid) nv++;
      end
      chk({name, "_len"}, 32'(n), 32'd32);
      chk({name, "_no_rd_valid"}, 32'(nv), 32'd0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);

      // Requests during the sweep must be ignored.
      rst = 1'b0;
      drive(1'b1, 5'd0, 16'hFFFF, 2'b11, 1'b1, 5'd0);
      wait_sweep("sweep1");
      idle();

      for (int a = 0; a < 32; a++) begin
         drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
         tick();
         chk("clr_read_valid", 32'(rd_valid), 32'h1);
         chk("clr_read_data", 32'(rd_data), 32'h0);
      end
      idle();
      tick();
      chk("idle_valid_low", 32'(rd_valid), 32'h0);

      drive(1'b1, 5'd3, 16'h00A5, 2'b11, 1'b0, '0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 5'd3);
      tick();
      chk("rd_a5_data", 32'(rd_data), 32'h00A5);
      chk("rd_a5_valid", 32'(rd_valid), 32'h1);

      drive(1'b1, 5'd7, 16'h1234, 2'b11, 1'b0, '0);
      tick();
      drive(1'b1, 5'd7, 16'hFFFF, 2'b10, 1'b0, '0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 5'd7);
      tick();
      chk("byte_en_ff34", 32'(rd_data), 32'hFF34);

      drive(1'b1, 5'd9, 16'h005C, 2'b11, 1'b1, 5'd9);
      tick();
      chk("wf_data", 32'(rd_data), 32'h005C);
      chk("wf_valid", 32'(rd_valid), 32'h1);
      idle();
      tick();
      chk("hold_valid", 32'(rd_valid), 32'h0);
      chk("hold_data", 32'(rd_data), 32'h005C);

      // Partial write-first: low lane new, high lane old.
      drive(1'b1, 5'd7, 16'hABCD, 2'b01, 1'b1, 5'd7);
      tick();
      chk("wf_partial", 32'(rd_data), 32'hFFCD);

      drive(1'b1, 5'd3, 16'h0000, 2'b00, 1'b0, '0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 5'd3);
      tick();
      chk("be_zero_keeps", 32'(rd_data), 32'h00A5);

`ifdef RAM_DP_PARITY_EN
      par_inj = 1'b1;
      drive(1'b1, 5'd2, 16'h003C, 2'b11, 1'b0, '0);
      tick();
      par_inj = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b1, 5'd2);
      tick();
      chk("par_inj_err", 32'(par_err), 32'h1);
      chk("par_inj_valid", 32'(rd_valid), 32'h1);
      drive(1'b1, 5'd4, 16'h003C, 2'b11, 1'b0, '0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 5'd4);
      tick();
      chk("par_ok", 32'(par_err), 32'h0);
`endif

      // Reset on top of a pending read drops it.
      drive(1'b0, '0, '0, '0, 1'b1, 5'd3);
      rst = 1'b1;
      tick();
      chk("rst_mid_read_valid", 32'(rd_valid), 32'h0);
      chk("rst_mid_read_data", 32'(rd_data), 32'h0);
      chk("rst_mid_read_busy", 32'(busy), 32'h1);

      // Reset again at sweep count 10 restarts the full sweep.
      rst = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("mid_sweep_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_sweep("sweep2");
      idle();

      drive(1'b0, '0, '0, '0, 1'b1, 5'd3);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 5'd7);
      chk("post_clr_a3", 32'(rd_data), 32'h0);
      chk("post_clr_a3_valid", 32'(rd_valid), 32'h1);
      tick();
      chk("post_clr_a7", 32'(rd_data), 32'h0);
      chk("b2b_valid", 32'(rd_valid), 32'h1);
      idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; depth DEPTH = 2**ADDR_WIDTH is a derived localparam.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write request.
REQ-006 SHALL have port wr_addr  input  ADDR_WIDTH  write address.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-008 SHALL have port wr_be  input  DATA_WIDTH/8  byte-lane write enables; bit i covers wr_data[8i+7:8i].
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data as new.
REQ-013 SHALL have port busy  output  1  high while reset or the clear sweep is active.

Function
REQ-014 SHALL implement an FSM with states ST_CLEAR and ST_READY; rst forces ST_CLEAR with clear counter = 0.
REQ-015 In ST_CLEAR, SHALL write all-zero to address clr_cnt each cycle and increment; SHALL go to ST_READY after writing DEPTH-1, i.e. DEPTH cycles after rst deasserts.
REQ-016 busy SHALL be 1 in ST_CLEAR and 0 in ST_READY; wr_en and rd_en SHALL be ignored while busy=1 (no write, no rd_valid).
REQ-017 In ST_READY, wr_en=1 SHALL update only byte lanes with wr_be[i]=1; wr_be=0 SHALL leave memory unchanged.
REQ-018 Read latency SHALL be 1: rd_en=1 in cycle N gives rd_data and rd_valid=1 in cycle N+1.
REQ-019 With no accepted read, rd_valid SHALL be 0 and rd_data SHALL hold its last value (never X).
REQ-020 On a same-cycle read and write to the same address, the read SHALL be write-first: enabled lanes return wr_data, other lanes return the old contents.
REQ-021 Back-to-back reads SHALL be accepted every cycle, giving one rd_valid per request.

Reset
REQ-022 On rst: rd_data=0, rd_valid=0, busy=1, state=ST_CLEAR.
REQ-023 rst asserted mid-sweep or mid-read SHALL restart the sweep at address 0 and drop any pending rd_valid.

Configuration
REQ-024 Macro RAM_DP_PARITY_EN SHALL add one even-parity bit per byte lane to storage, plus ports par_inj (input, 1) and par_err (output, 1).
REQ-025 With RAM_DP_PARITY_EN: par_inj=1 with a write SHALL store inverted parity for the enabled lanes; the clear sweep SHALL write correct parity; par_err SHALL be 1 with rd_valid when any lane mismatches, else 0; par_err SHALL reset to 0.
REQ-026 Without RAM_DP_PARITY_EN: no parity storage, no par_inj or par_err ports, all other behaviour identical.

Structure
REQ-027 Package ram_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the FSM state typedef.
REQ-028 The FSM and clear counter SHALL be in sub-module ram_dp_clear_ctrl (outputs busy, clr_we, clr_addr); the storage array SHALL stay in ram_dp.

Verification
REQ-029 Reset then deassert -> busy=1 for exactly 32 cycles (defaults), and reading 0..31 afterwards returns 0x00 each.
REQ-030 Write 0xA5 to addr 3, then rd_en addr 3 next cycle -> rd_data=0xA5 with rd_valid=1 one cycle later.
REQ-031 DATA_WIDTH=16: write 0x1234 to addr 7, then write 0xFFFF with wr_be=2'b10 -> reading addr 7 returns 0xFF34.
REQ-032 Same cycle: write 0x5C to addr 9 and read addr 9 -> rd_data=0x5C; rd_en=0 next cycle -> rd_valid=0 and rd_data stays 0x5C.
REQ-033 Assert rst at sweep count 10 -> busy stays 1 for a full 32 cycles after deassert; rd_en during busy -> no rd_valid.
REQ-034 With RAM_DP_PARITY_EN: write 0x3C with par_inj=1 to addr 2, then read -> par_err=1 with rd_valid; normal write then read -> par_err=0.
